// File: rtl/ctrl_sequencer_if.sv
// Control bundle between the sequencer and the accumulator-machine datapath.
// The sequencer takes the master side; the datapath and bench take the slave side.
interface ctrl_sequencer_if;
   logic       run;
   logic [3:0] ir_op;
   logic [5:0] tstate;
   logic       pc_inc;
   logic       pc_oe;
   logic       pc_ld;
   logic       mar_ld;
   logic       ram_oe;
   logic       ir_ld;
   logic       ir_oe;
   logic       a_ld;
   logic       a_oe;
   logic       b_ld;
   logic       alu_oe;
   logic       alu_sub;
   logic       out_ld;
   logic       halt;

   modport master (
      input  run, ir_op,
      output tstate, pc_inc, pc_oe, pc_ld, mar_ld, ram_oe, ir_ld, ir_oe,
             a_ld, a_oe, b_ld, alu_oe, alu_sub, out_ld, halt
   );

   modport slave (
      output run, ir_op,
      input  tstate, pc_inc, pc_oe, pc_ld, mar_ld, ram_oe, ir_ld, ir_oe,
             a_ld, a_oe, b_ld, alu_oe, alu_sub, out_ld, halt
   );
endinterface

// File: rtl/ctrl_sequencer.sv
// Six-state one-hot ring sequencer decoding T-state and opcode into datapath strobes.
// Define SEQ_JMP_EN to enable the JMP opcode (otherwise JMP is a NOP and pc_ld is tied low).
module ctrl_sequencer (
   input  logic       clk,
   input  logic       reset,
   ctrl_sequencer_if.master bus
);

   typedef enum logic [5:0] {
      StT1 = 6'b000001,
      StT2 = 6'b000010,
      StT3 = 6'b000100,
      StT4 = 6'b001000,
      StT5 = 6'b010000,
      StT6 = 6'b100000
   } state_e;

   localparam logic [3:0] OpLda = 4'h0;
   localparam logic [3:0] OpAdd = 4'h1;
   localparam logic [3:0] OpSub = 4'h2;
`ifdef SEQ_JMP_EN
   localparam logic [3:0] OpJmp = 4'h3;
`endif
   localparam logic [3:0] OpOut = 4'hE;
   localparam logic [3:0] OpHlt = 4'hF;

   state_e t_q, t_d;
   logic   halted_q, halted_d;
   logic   hlt_now;

   logic pc_inc, pc_oe, pc_ld, mar_ld, ram_oe, ir_ld, ir_oe;
   logic a_ld, a_oe, b_ld, alu_oe, alu_sub, out_ld, halt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         t_q      <= StT1;
         halted_q <= 1'b0;
      end else begin
         t_q      <= t_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      t_d      = t_q;
      halted_d = halted_q;
      pc_inc   = 1'b0;
      pc_oe    = 1'b0;
      pc_ld    = 1'b0;
      mar_ld   = 1'b0;
      ram_oe   = 1'b0;
      ir_ld    = 1'b0;
      ir_oe    = 1'b0;
      a_ld     = 1'b0;
      a_oe     = 1'b0;
      b_ld     = 1'b0;
      alu_oe   = 1'b0;
      alu_sub  = 1'b0;
      out_ld   = 1'b0;

      hlt_now = (t_q == StT4) && (bus.ir_op == OpHlt);

      // Halt freezes the ring at T4 regardless of run.
      if (!halted_q) begin
         if (hlt_now) begin
            halted_d = 1'b1;
         end else if (bus.run) begin
            unique case (t_q)
               StT1:    t_d = StT2;
               StT2:    t_d = StT3;
               StT3:    t_d = StT4;
               StT4:    t_d = StT5;
               StT5:    t_d = StT6;
               StT6:    t_d = StT1;
               default: t_d = StT1;
            endcase
         end
      end

      // Strobes are suppressed during reset so nothing loads while it is held.
      if (reset && !halted_q) begin
         unique case (t_q)
            StT1: begin
               pc_oe  = 1'b1;
               mar_ld = 1'b1;
            end
            StT2: pc_inc = 1'b1;
            StT3: begin
               ram_oe = 1'b1;
               ir_ld  = 1'b1;
            end
            StT4: begin
               case (bus.ir_op)
                  OpLda, OpAdd, OpSub: begin
                     ir_oe  = 1'b1;
                     mar_ld = 1'b1;
                  end
                  OpOut: begin
                     a_oe   = 1'b1;
                     out_ld = 1'b1;
                  end
`ifdef SEQ_JMP_EN
                  OpJmp: begin
                     ir_oe = 1'b1;
                     pc_ld = 1'b1;
                  end
`endif
                  default: ;
               endcase
            end
            StT5: begin
               case (bus.ir_op)
                  OpLda: begin
                     ram_oe = 1'b1;
                     a_ld   = 1'b1;
                  end
                  OpAdd, OpSub: begin
                     ram_oe  = 1'b1;
                     b_ld    = 1'b1;
                     alu_sub = (bus.ir_op == OpSub);
                  end
                  default: ;
               endcase
            end
            StT6: begin
               if (bus.ir_op == OpAdd || bus.ir_op == OpSub) begin
                  alu_oe  = 1'b1;
                  a_ld    = 1'b1;
                  alu_sub = (bus.ir_op == OpSub);
               end
            end
            default: ;
         endcase
      end

      halt = reset && (halted_q || hlt_now);
   end

   assign bus.tstate  = t_q;
   assign bus.pc_inc  = pc_inc;
   assign bus.pc_oe   = pc_oe;
   assign bus.pc_ld   = pc_ld;
   assign bus.mar_ld  = mar_ld;
   assign bus.ram_oe  = ram_oe;
   assign bus.ir_ld   = ir_ld;
   assign bus.ir_oe   = ir_oe;
   assign bus.a_ld    = a_ld;
   assign bus.a_oe    = a_oe;
   assign bus.b_ld    = b_ld;
   assign bus.alu_oe  = alu_oe;
   assign bus.alu_sub = alu_sub;
   assign bus.out_ld  = out_ld;
   assign bus.halt    = halt;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: expected tstate/strobes come from a per-opcode table.
// Honours SEQ_JMP_EN the same way the design does.
module tb_ctrl_sequencer;

   logic clk;
   logic reset;
   ctrl_sequencer_if sq ();

   ctrl_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  t;
      logic [13:0] s;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   m_t   = 0;
   bit   m_halted = 1'b0;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Order: pc_inc pc_oe pc_ld mar_ld ram_oe ir_ld ir_oe a_ld a_oe b_ld alu_oe alu_sub out_ld halt
   function automatic logic [13:0] exp_strobes(int ti, logic [3:0] op, bit hlt, logic rst);
      logic pc_inc = 0, pc_oe = 0, pc_ld = 0, mar_ld = 0, ram_oe = 0, ir_ld = 0, ir_oe = 0;
      logic a_ld = 0, a_oe = 0, b_ld = 0, alu_oe = 0, alu_sub = 0, out_ld = 0, halt = 0;
      if (!rst) return 14'h0;
      if (hlt) return 14'h1;
      case (ti)
         0: begin pc_oe = 1; mar_ld = 1; end
         1: pc_inc = 1;
         2: begin ram_oe = 1; ir_ld = 1; end
         3: begin
            if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin ir_oe = 1; mar_ld = 1; end
            if (op == 4'hE) begin a_oe = 1; out_ld = 1; end
            if (op == 4'hF) halt = 1;
`ifdef SEQ_JMP_EN
            if (op == 4'h3) begin ir_oe = 1; pc_ld = 1; end
`endif
         end
         4: begin
            if (op == 4'h0) begin ram_oe = 1; a_ld = 1; end
            if (op == 4'h1) begin ram_oe = 1; b_ld = 1; end
            if (op == 4'h2) begin ram_oe = 1; b_ld = 1; alu_sub = 1; end
         end
         5: begin
            if (op == 4'h1) begin alu_oe = 1; a_ld = 1; end
            if (op == 4'h2) begin alu_oe = 1; a_ld = 1; alu_sub = 1; end
         end
         default: ;
      endcase
      return {pc_inc, pc_oe, pc_ld, mar_ld, ram_oe, ir_ld, ir_oe,
              a_ld, a_oe, b_ld, alu_oe, alu_sub, out_ld, halt};
   endfunction

   // One cycle: drive at negedge, push expectation, compare mid-cycle, advance model at posedge.
   task automatic step(input logic rst, input logic rn, input logic [3:0] op);
      exp_t e;
      exp_t g;
      reset    = rst;
      sq.run   = rn;
      sq.ir_op = op;
      e.t = 6'b000001 << m_t;
      e.s = exp_strobes(m_t, op, m_halted, rst);
      sb.push_back(e);
      #2;
      g = sb.pop_front();
      check_eq("tstate", {10'h0, sq.tstate}, {10'h0, g.t});
      check_eq("strobes", {2'b0, sq.pc_inc, sq.pc_oe, sq.pc_ld, sq.mar_ld, sq.ram_oe, sq.ir_ld,
                           sq.ir_oe, sq.a_ld, sq.a_oe, sq.b_ld, sq.alu_oe, sq.alu_sub,
                           sq.out_ld, sq.halt}, {2'b0, g.s});
      @(posedge clk);
      if (!rst) begin
         m_t = 0;
         m_halted = 1'b0;
      end else if (!m_halted) begin
         if (m_t == 3 && op == 4'hF) m_halted = 1'b1;
         else if (rn) m_t = (m_t + 1) % 6;
      end
      @(negedge clk);
   endtask

   task automatic run_instr(input logic [3:0] op);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, op);
   endtask

   initial begin
      reset    = 1'b0;
      sq.run   = 1'b1;
      sq.ir_op = 4'h0;
      @(negedge clk);

      step(1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b1, 4'h0);

      run_instr(4'h0);
      run_instr(4'h1);
      run_instr(4'h2);
      run_instr(4'hE);
      run_instr(4'h7);
      run_instr(4'h3);

      // Hold in T2 for three edges, then resume.
      step(1'b1, 1'b1, 4'h0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'h0);

      // Reset in T5 abandons the instruction.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'h1);
      step(1'b0, 1'b1, 4'h1);
      run_instr(4'h1);

      // Halt, hold frozen with random run, then recover via reset.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'hF);
      for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)), 4'hF);
      step(1'b0, 1'b1, 4'hF);
      run_instr(4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Controller-sequencer for the 8-bit accumulator machine. A six-state one-hot ring counter (T1–T6) combines with the 4-bit opcode from the instruction register to produce every register load and output-enable strobe for one instruction. It sits directly upstream of the A register and drives its load enable (`a_ld` → `en`), along with the enables for PC, MAR, RAM, IR, B, ALU and OUT.

## Interface
- OP_LDA, 4'h0, load A from memory
- OP_ADD, 4'h1, A ← A + mem
- OP_SUB, 4'h2, A ← A − mem
- OP_JMP, 4'h3, PC ← IR operand (only with SEQ_JMP_EN)
- OP_OUT, 4'hE, OUT ← A
- OP_HLT, 4'hF, stop the sequencer

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- run  in  1  1 = advance ring each cycle, 0 = hold current T-state
- ir_op  in  4  opcode nibble from IR; used only in T4–T6
- tstate  out  6  one-hot T-state; bit0 = T1
- pc_inc, pc_oe, pc_ld  out  1 each  program counter increment, bus drive, load
- mar_ld  out  1  MAR load
- ram_oe  out  1  RAM drives bus
- ir_ld, ir_oe  out  1 each  IR load, IR operand drives bus
- a_ld, a_oe  out  1 each  A register enable, A drives bus
- b_ld  out  1  B register load
- alu_oe, alu_sub  out  1 each  ALU drives bus, subtract select
- out_ld  out  1  output register load
- halt  out  1  machine halted

## Operation
- State: `t[5:0]` one-hot, plus a `halted` flag. Both are registered.
- Control outputs are combinational decodes of `t`, `ir_op` and `halted`. This makes them valid for the whole cycle; consumers sample them at the next rising edge.
- Fetch (all opcodes):
  - T1: pc_oe, mar_ld
  - T2: pc_inc
  - T3: ram_oe, ir_ld
- Execute:
  - LDA: T4 ir_oe, mar_ld; T5 ram_oe, a_ld; T6 nothing
  - ADD: T4 ir_oe, mar_ld; T5 ram_oe, b_ld; T6 alu_oe, a_ld
  - SUB: same as ADD, with alu_sub=1 in T5 and T6
  - OUT: T4 a_oe, out_ld; T5–T6 nothing
  - HLT: T4 halt=1; all other strobes stay 0
  - Undefined opcode: T4–T6 nothing (NOP)
- Ring advance:
  - On a clock edge with run=1 and not halted: T1→T2→…→T6→T1.
  - With run=0, `t` holds; strobes of the held state remain asserted. Single-stepping means pulsing run for one cycle.
- Halt:
  - The edge in T4 with ir_op=OP_HLT sets `halted`.
  - While halted: `t` is frozen at T4, halt=1, every other strobe is 0, and run is ignored.
  - Only reset clears the halted state.
- Reset (reset=0 at an edge):
  - t←T1 (tstate=6'b000001), halted←0.
  - While reset=0, all strobe outputs and halt are forced to 0 combinationally, so no register loads during reset. tstate still shows the registered state.
- Reset mid-instruction abandons the instruction; the first cycle after release is T1 with pc_oe=mar_ld=1.
- At most one bus driver (pc_oe, ram_oe, ir_oe, a_oe, alu_oe) is asserted in any state.

## Timing
- One T-state per clock with run=1; every instruction takes exactly 6 cycles, including NOP and OUT.
- `a_ld` asserted in cycle Tn means A captures the bus at the edge ending Tn. ADD result is in A one edge after T6.
- `ir_op` must be stable from the edge ending T3 through T6; it is not examined in T1–T3.
- run deasserted in Tn: the edge ending Tn does not advance. Loads decoded for Tn re-fire at each held edge. Run is a debug/step input and is not allowed to drop mid-instruction in normal operation.
- Halt becomes visible in the T4 cycle itself (combinational) and stays registered thereafter.

## Configuration
- `SEQ_JMP_EN` defined:
  - OP_JMP decodes to T4: ir_oe, pc_ld; T5–T6 nothing.
- `SEQ_JMP_EN` undefined:
  - OP_JMP is an undefined opcode (NOP).
  - pc_ld is tied to 0.
  - The port is always present.

## Test plan
- Reset: reset=0 for 2 edges with run=1 → tstate=6'b000001, all strobes 0 and halt=0 during reset; first cycle after release shows pc_oe=mar_ld=1.
- LDA: ir_op=4'h0, run=1 → T4 ir_oe+mar_ld, T5 ram_oe+a_ld, T6 no strobes, then back to T1; a_ld high for exactly 1 of 6 cycles.
- SUB: ir_op=4'h2 → T5 ram_oe+b_ld+alu_sub, T6 alu_oe+a_ld+alu_sub; no other cycle asserts alu_sub.
- HLT: ir_op=4'hF → halt=1 from T4 on; tstate stays 6'b001000 for 20 cycles with all strobes 0; reset=0 for one edge → T1, halt=0.
- Step/hold: run=0 during T2 for 3 edges → tstate stays 6'b000010 and pc_inc stays high; run=1 → T3 on the next edge.
- JMP: ir_op=4'h3 with SEQ_JMP_EN → T4 ir_oe+pc_ld; without the macro → pc_ld stays 0 in all states and T4–T6 show no strobes.
